// File: rtl/cgra_axis_upsizer.sv
// cgra_axis_upsizer: packs BEATS narrow DMA AXI-Stream words into one wide
// beat for the CGRA AXIS bridge ingress. Little-endian: word 0 -> [DATA_W-1:0].
// Registered output stage, 1 narrow beat/cycle sustained.
// Optional: define CGRA_UPSIZER_ERRCNT_EN to add the err_short_cnt port,
// a saturating count of groups closed early by tlast.
module cgra_axis_upsizer #(
    parameter int DATA_W = 64,
    parameter int AXIS_W = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
`ifdef CGRA_UPSIZER_ERRCNT_EN
    ,
    output logic [15:0]       err_short_cnt
`endif
);

    localparam int BEATS = AXIS_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    if (((AXIS_W % DATA_W) != 0) || (BEATS < 2)) begin : g_param_chk
        $error("cgra_axis_upsizer: AXIS_W must be a multiple (>=2x) of DATA_W");
    end

    logic [CNT_W-1:0]              r_cnt;
    logic [BEATS-1:0][DATA_W-1:0]  r_acc;
    logic [BEATS-1:0][DATA_W-1:0]  r_out_data;
    logic                          r_out_valid;
    logic                          r_out_last;

    logic [BEATS-1:0][DATA_W-1:0]  w_assembled;
    logic                          w_ready;
    logic                          w_accept;
    logic                          w_complete;

    // Ready depends only on output-stage occupancy, never on s_axis_tvalid.
    assign w_ready    = !rst && (!r_out_valid || m_axis_tready);
    assign w_accept   = s_axis_tvalid && w_ready;
    assign w_complete = w_accept && ((r_cnt == LAST_IDX) || s_axis_tlast);

    // Merge the incoming word into slot cnt; slots above cnt are forced to zero.
    always_comb begin
        w_assembled = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (CNT_W'(i) == r_cnt)
                w_assembled[i] = s_axis_tdata;
            else if (CNT_W'(i) < r_cnt)
                w_assembled[i] = r_acc[i];
            else
                w_assembled[i] = '0;
        end
    end

    // Accumulator and slot index; cleared whenever a group closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_assembled;
            end
        end
    end

    // Output register: load on completion (even during a handshake, giving
    // back-to-back beats), drop valid on a handshake with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_assembled;
            r_out_last  <= s_axis_tlast;
        end else if (r_out_valid && m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;

`ifdef CGRA_UPSIZER_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_short;

    // A completion before the last slot can only have been caused by tlast.
    assign w_short = w_complete && (r_cnt != LAST_IDX);

    // Saturating short-group counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_short && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_short_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_cgra_axis_upsizer.sv
// Testbench for cgra_axis_upsizer: directed steps plus random traffic,
// checked against a queue-based packet model of the upsizer.
module tb_cgra_axis_upsizer;

    localparam int DATA_W = 64;
    localparam int AXIS_W = 192;
    localparam int BEATS  = AXIS_W / DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [AXIS_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
`ifdef CGRA_UPSIZER_ERRCNT_EN
    logic [15:0]       err_short_cnt;
`endif

    cgra_axis_upsizer #(.DATA_W(DATA_W), .AXIS_W(AXIS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
`ifdef CGRA_UPSIZER_ERRCNT_EN
        ,
        .err_short_cnt(err_short_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AXIS_W-1:0] data;
        logic              last;
    } beat_t;

    // Reference model: words of the open group, wide beats not yet delivered.
    logic [DATA_W-1:0] grp[$];
    beat_t             exp_q[$];
    int                exp_err;
    int                n_delivered;
    bit                accepted;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [AXIS_W-1:0] obs,
                         input logic [AXIS_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluate one cycle just before the clock edge: compare, then advance the model.
    task automatic observe();
        logic  exp_rdy;
        beat_t b;
        accepted = 1'b0;
        if (rst) begin
            check("rst_s_tready", AXIS_W'(s_axis_tready), '0);
            grp.delete();
            exp_q.delete();
            exp_err = 0;
            return;
        end
        exp_rdy = (exp_q.size() == 0) || m_axis_tready;
        check("s_tready", AXIS_W'(s_axis_tready), AXIS_W'(exp_rdy));
        check("m_tvalid", AXIS_W'(m_axis_tvalid), AXIS_W'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("m_tdata", m_axis_tdata, exp_q[0].data);
            check("m_tlast", AXIS_W'(m_axis_tlast), AXIS_W'(exp_q[0].last));
            if (m_axis_tready) begin
                void'(exp_q.pop_front());
                n_delivered++;
            end
        end
        if (s_axis_tvalid && exp_rdy) begin
            accepted = 1'b1;
            grp.push_back(s_axis_tdata);
            if (grp.size() == BEATS || s_axis_tlast) begin
                b.data = '0;
                for (int k = 0; k < grp.size(); k++)
                    b.data[k*DATA_W +: DATA_W] = grp[k];
                b.last = s_axis_tlast;
                if (grp.size() < BEATS && exp_err < 16'hFFFF) exp_err++;
                exp_q.push_back(b);
                grp.delete();
            end
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (accepted) return;
        end
        check("send_timeout", '0, AXIS_W'(1));
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [AXIS_W-1:0] ref_word;
        int                d0;

        exp_err       = 0;
        n_delivered   = 0;
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hDEAD;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset with tvalid held high
        @(posedge clk);
        #2;
        tick();
        tick();
        check("rst_m_tvalid", AXIS_W'(m_axis_tvalid), '0);
        check("rst_m_tdata", m_axis_tdata, '0);
        rst = 1'b0;
        idle(2);

        // Full group A,B,C with tlast on C
        send_word(64'hA, 1'b0);
        send_word(64'hB, 1'b0);
        check("full_no_early_valid", AXIS_W'(m_axis_tvalid), '0);
        send_word(64'hC, 1'b1);
        ref_word = {64'hC, 64'hB, 64'hA};
        check("full_valid", AXIS_W'(m_axis_tvalid), AXIS_W'(1));
        check("full_data", m_axis_tdata, ref_word);
        check("full_last", AXIS_W'(m_axis_tlast), AXIS_W'(1));
        idle(3);

        // Streaming 12 words, tlast only on the last
        for (int i = 0; i < 12; i++) begin
            send_word({$urandom, $urandom}, i == 11);
            check("stream_tready", AXIS_W'(s_axis_tready), AXIS_W'(1));
        end
        idle(3);
        check("stream_beats", AXIS_W'(n_delivered), AXIS_W'(5));

        // Backpressure: stall for 5 cycles once a wide beat is valid
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0);
        ref_word = m_axis_tdata;
        s_axis_tdata  = 64'h1111_2222_3333_4444;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_tready", AXIS_W'(s_axis_tready), '0);
            check("bp_hold", m_axis_tdata, ref_word);
        end
        m_axis_tready = 1'b1;
        send_word(64'h1111_2222_3333_4444, 1'b0);
        send_word(64'h5555, 1'b0);
        send_word(64'h6666, 1'b1);
        check("bp_after", m_axis_tdata, {64'h6666, 64'h5555, 64'h1111_2222_3333_4444});
        idle(3);

        // Short group: two words, tlast on the second
        send_word(64'h1, 1'b0);
        send_word(64'h2, 1'b1);
        check("short_data", m_axis_tdata, {64'h0, 64'h2, 64'h1});
        check("short_last", AXIS_W'(m_axis_tlast), AXIS_W'(1));
        idle(2);
`ifdef CGRA_UPSIZER_ERRCNT_EN
        check("short_errcnt", AXIS_W'(err_short_cnt), AXIS_W'(exp_err));
`endif

        // Reset mid-group: partial word must vanish
        send_word(64'hBAD, 1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = n_delivered;
        send_word(64'hF1, 1'b0);
        send_word(64'hF2, 1'b0);
        send_word(64'hF3, 1'b1);
        check("midrst_data", m_axis_tdata, {64'hF3, 64'hF2, 64'hF1});
        idle(3);
        check("midrst_beats", AXIS_W'(n_delivered - d0), AXIS_W'(1));
`ifdef CGRA_UPSIZER_ERRCNT_EN
        check("midrst_errcnt", AXIS_W'(err_short_cnt), '0);
`endif

        // Random traffic with random gaps and backpressure
        for (int i = 0; i < 300; i++) begin
            m_axis_tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tlast  = ($urandom_range(0, 9) == 0);
                s_axis_tvalid = 1'b1;
                // Hold the word until the model says it was taken
                for (int n = 0; n < 50; n++) begin
                    tick();
                    if (accepted) break;
                    m_axis_tready = ($urandom_range(0, 9) < 7);
                end
            end
        end
        m_axis_tready = 1'b1;
        idle(4);
        check("drain_empty", AXIS_W'(m_axis_tvalid), '0);
`ifdef CGRA_UPSIZER_ERRCNT_EN
        check("rand_errcnt", AXIS_W'(err_short_cnt), AXIS_W'(exp_err));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
